sd_cmd_sender: RTL
==================

# sd_cmd_sender

Byte-level SD-card command sequencer in SPI mode; it sits directly upstream of the `spi_master` byte engine. On one start pulse it asserts card chip-select and streams the 6-byte command frame, computing CRC7 internally. It then polls with 0xFF bytes for the R1 response and clocks one trailing 0xFF byte before releasing chip-select. It is the building block for the card init and block-read sequencers.

## Interface
- `MAX_POLL`, default 8: maximum number of 0xFF poll bytes sent while waiting for R1. Legal range is 1..255.
- `I_clk`  in  1  system clock, shared with `spi_master`.
- `I_rst_n`  in  1  asynchronous active-low reset.
- `I_start`  in  1  one-cycle command request. Sampled only when `O_busy`=0.
- `I_cmd_index`  in  6  SD command number.
- `I_arg`  in  32  command argument.
- `O_busy`  out  1  high from the cycle after start acceptance until `O_done`.
- `O_done`  out  1  one-cycle completion pulse.
- `O_r1`  out  8  R1 response byte. Valid from `O_done` and held until the next start.
- `O_timeout`  out  1  no R1 within `MAX_POLL` bytes. Valid and held like `O_r1`.
- `O_cs_n`  out  1  card chip-select, active low.
- `O_spi_write`  out  1  byte request to `spi_master`.
- `O_spi_data`  out  8  byte to transmit.
- `I_spi_busy`  in  1  `spi_master` busy flag. It is 1 out of reset, and 1 during a transfer.
- `I_spi_ready`  in  1  `spi_master` received-byte valid.
- `I_spi_data`  in  8  received byte.
- `O_spi_read`  out  1  one-cycle acknowledge of the received byte.

## Operation
- Reset values:
  - `O_busy`=0, `O_done`=0, `O_timeout`=0, `O_spi_write`=0, `O_spi_read`=0
  - `O_cs_n`=1
  - `O_r1`=8'hFF, `O_spi_data`=8'hFF
  - FSM in IDLE
- Frame, MSB first:
  - byte0 = {2'b01, `I_cmd_index`}
  - bytes1..4 = `I_arg`[31:24]..[7:0]
  - byte5 = {crc7, 1'b1}
- Index and argument are latched at start. Later input changes have no effect.
- CRC7:
  - Polynomial x^7+x^3+1, register initialised to 0 at start.
  - Updated MSB-first over bytes0..4, as each byte is loaded into `O_spi_data`.
  - The 8-bit update is a combinational function; no extra cycles.
- FSM states:
  - IDLE: on `I_start` → LOAD, with `O_busy`=1, `O_cs_n`=0, `O_timeout`=0, byte counter=0, poll counter=0.
  - LOAD: drive `O_spi_data` with the next byte. Frame bytes come from the counter; in poll/trailer phases the byte is 0xFF. → SEND.
  - SEND: wait for `I_spi_busy`=0, then assert `O_spi_write` for exactly one cycle. → ACK.
  - ACK: wait for `I_spi_busy`=1 (byte accepted). → WAIT.
  - WAIT: wait for `I_spi_ready`=1, capture `I_spi_data`, pulse `O_spi_read` for one cycle. → EVAL.
  - EVAL, frame phase: if byte counter < 5, increment and → LOAD. Otherwise enter the poll phase and → LOAD.
  - EVAL, poll phase (the captured byte counts as one poll):
    - Captured bit7=0: `O_r1`=captured byte, enter trailer → LOAD.
    - Otherwise, if poll counter+1 = `MAX_POLL`: `O_timeout`=1, `O_r1`=8'hFF, enter trailer → LOAD.
    - Otherwise increment poll counter → LOAD.
  - EVAL, trailer phase: → FINISH.
  - FINISH: `O_cs_n`=1, `O_busy`=0, `O_done`=1 for one cycle. → IDLE.
- Bytes received during frame bytes0..5 are discarded.
- `I_start` while `O_busy`=1 is ignored; there is no queueing.
- `I_spi_ready` is acknowledged only in WAIT. It is never sampled in the cycle after `O_spi_read`.
- Reset mid-operation aborts immediately to reset values: CS high, no done pulse.

## Timing
- Start accepted at edge N. At N+1: `O_busy`=1, `O_cs_n`=0, FSM in LOAD.
- `O_spi_write` is never high in two consecutive cycles, and never high while `I_spi_busy`=1.
- One byte costs 4 cycles of fixed overhead (LOAD, SEND, ACK, EVAL) plus the `spi_master` transfer time.
- Total transfers per command: 6 frame + k poll + 1 trailer, with 1 ≤ k ≤ `MAX_POLL`.
- `O_cs_n` stays low continuously from N+1 through the trailer byte. It rises in the same cycle `O_done` pulses.
- `O_done` and `O_busy` falling coincide. A new `I_start` is accepted on the next cycle.

## Test plan
- CMD0: start, idx=0, arg=0. Slave returns FF, then 01. Required: MOSI bytes 40 00 00 00 00 95 FF FF FF; `O_r1`=01, `O_timeout`=0, single `O_done`, CS low for exactly 9 bytes.
- CMD8: idx=8, arg=0x000001AA, slave returns 01 on the first poll. Required: frame 48 00 00 01 AA 87; `O_r1`=01.
- CMD55: idx=55, arg=0. Required: frame 77 00 00 00 00 65.
- Timeout: MISO constant FF, `MAX_POLL`=8. Required: exactly 8 poll bytes plus 1 trailer; `O_timeout`=1, `O_r1`=FF.
- Start pulses during an active command, and hold `I_spi_busy` high 20 cycles after reset. Required: extra starts ignored; first `O_spi_write` only after busy falls.
- Assert `I_rst_n`=0 during frame byte 3. Required: all outputs return to reset values asynchronously, `O_cs_n`=1, no `O_done`. A subsequent CMD0 completes normally.

Source files
------------

// File: rtl/sd_cmd_sender.sv
// ---------------------------------------------------------------------------
// sd_cmd_sender
//
// Byte-level SD-card command sequencer (SPI mode) sitting directly upstream
// of the spi_master byte engine. One start pulse drops chip-select, streams
// the 6-byte command frame (CRC7 computed on the fly), polls with 0xFF bytes
// until an R1 byte (bit7 = 0) arrives or MAX_POLL polls are spent, clocks a
// single trailing 0xFF byte and then releases chip-select with a done pulse.
//
// Parameters
//   MAX_POLL     maximum number of 0xFF poll bytes while waiting for R1 (1..255)
//
// Ports
//   I_clk        system clock, shared with spi_master
//   I_rst_n      asynchronous active-low reset
//   I_start      one-cycle command request, sampled only while idle
//   I_cmd_index  SD command number (latched at start)
//   I_arg        32-bit command argument (latched at start)
//   O_busy       high from the cycle after start acceptance until O_done
//   O_done       one-cycle completion pulse
//   O_r1         R1 response byte, valid from O_done until the next start
//   O_timeout    no R1 within MAX_POLL polls, valid like O_r1
//   O_cs_n       card chip-select, active low
//   O_spi_write  byte request to spi_master
//   O_spi_data   byte to transmit
//   I_spi_busy   spi_master busy flag (high out of reset and during a transfer)
//   I_spi_ready  spi_master received-byte valid
//   I_spi_data   received byte
//   O_spi_read   one-cycle acknowledge of the received byte
// ---------------------------------------------------------------------------
module sd_cmd_sender #(
    parameter int MAX_POLL = 8
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic        I_start,
    input  logic [5:0]  I_cmd_index,
    input  logic [31:0] I_arg,
    output logic        O_busy,
    output logic        O_done,
    output logic [7:0]  O_r1,
    output logic        O_timeout,
    output logic        O_cs_n,
    output logic        O_spi_write,
    output logic [7:0]  O_spi_data,
    input  logic        I_spi_busy,
    input  logic        I_spi_ready,
    input  logic [7:0]  I_spi_data,
    output logic        O_spi_read
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_ACK,
        ST_WAIT,
        ST_EVAL,
        ST_FINISH
    } state_e;

    // Which part of the command the current byte belongs to.
    typedef enum logic [1:0] {
        PH_FRAME,
        PH_POLL,
        PH_TRAILER
    } phase_e;

    localparam logic [7:0] MAX_POLL_B = 8'(MAX_POLL);
    localparam logic [2:0] LAST_FRAME = 3'd5;

    // CRC7 (x^7 + x^3 + 1) advanced by one byte, MSB first. Pure combinational
    // so the update costs no extra cycle when a frame byte is loaded.
    function automatic logic [6:0] crc7_byte(input logic [6:0] crc_in,
                                             input logic [7:0] data);
        logic [6:0] c;
        logic       fb;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[6] ^ data[i];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    state_e      state_q,    state_d;
    phase_e      phase_q,    phase_d;
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  poll_cnt_q, poll_cnt_d;
    logic [5:0]  cmd_idx_q,  cmd_idx_d;
    logic [31:0] arg_q,      arg_d;
    logic [6:0]  crc_q,      crc_d;
    logic [7:0]  rx_q,       rx_d;
    logic        busy_q,     busy_d;
    logic        done_q,     done_d;
    logic [7:0]  r1_q,       r1_d;
    logic        timeout_q,  timeout_d;
    logic        cs_n_q,     cs_n_d;
    logic [7:0]  spi_data_q, spi_data_d;
    logic        spi_read_q, spi_read_d;

    logic [7:0]  frame_byte;

    // Frame byte selected by the byte counter. Byte 5 uses the CRC register,
    // which by then has absorbed bytes 0..4.
    always_comb begin
        frame_byte = 8'hFF;
        unique case (byte_cnt_q)
            3'd0:    frame_byte = {2'b01, cmd_idx_q};
            3'd1:    frame_byte = arg_q[31:24];
            3'd2:    frame_byte = arg_q[23:16];
            3'd3:    frame_byte = arg_q[15:8];
            3'd4:    frame_byte = arg_q[7:0];
            3'd5:    frame_byte = {crc_q, 1'b1};
            default: frame_byte = 8'hFF;
        endcase
    end

    // NOTE: state registers use non-blocking assignments only, so every
    // always_ff samples the values from before the clock edge.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q    <= ST_IDLE;
            phase_q    <= PH_FRAME;
            byte_cnt_q <= '0;
            poll_cnt_q <= '0;
            cmd_idx_q  <= '0;
            arg_q      <= '0;
            crc_q      <= '0;
            rx_q       <= 8'hFF;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            r1_q       <= 8'hFF;
            timeout_q  <= 1'b0;
            cs_n_q     <= 1'b1;
            spi_data_q <= 8'hFF;
            spi_read_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            byte_cnt_q <= byte_cnt_d;
            poll_cnt_q <= poll_cnt_d;
            cmd_idx_q  <= cmd_idx_d;
            arg_q      <= arg_d;
            crc_q      <= crc_d;
            rx_q       <= rx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            r1_q       <= r1_d;
            timeout_q  <= timeout_d;
            cs_n_q     <= cs_n_d;
            spi_data_q <= spi_data_d;
            spi_read_q <= spi_read_d;
        end
    end

    // NOTE: every signal written here gets its default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        byte_cnt_d = byte_cnt_q;
        poll_cnt_d = poll_cnt_q;
        cmd_idx_d  = cmd_idx_q;
        arg_d      = arg_q;
        crc_d      = crc_q;
        rx_d       = rx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        r1_d       = r1_q;
        timeout_d  = timeout_q;
        cs_n_d     = cs_n_q;
        spi_data_d = spi_data_q;
        spi_read_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (I_start) begin
                    state_d    = ST_LOAD;
                    phase_d    = PH_FRAME;
                    busy_d     = 1'b1;
                    cs_n_d     = 1'b0;
                    timeout_d  = 1'b0;
                    byte_cnt_d = '0;
                    poll_cnt_d = '0;
                    crc_d      = '0;
                    cmd_idx_d  = I_cmd_index;
                    arg_d      = I_arg;
                end
            end

            ST_LOAD: begin
                if (phase_q == PH_FRAME) begin
                    spi_data_d = frame_byte;
                    if (byte_cnt_q < LAST_FRAME) begin
                        crc_d = crc7_byte(crc_q, frame_byte);
                    end
                end else begin
                    spi_data_d = 8'hFF;
                end
                state_d = ST_SEND;
            end

            // The write strobe itself is decoded combinationally below so it
            // can never coincide with a busy engine.
            ST_SEND: begin
                if (!I_spi_busy) begin
                    state_d = ST_ACK;
                end
            end

            // Busy rising proves spi_master took the byte.
            ST_ACK: begin
                if (I_spi_busy) begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (I_spi_ready) begin
                    rx_d       = I_spi_data;
                    spi_read_d = 1'b1;
                    state_d    = ST_EVAL;
                end
            end

            ST_EVAL: begin
                state_d = ST_LOAD;
                unique case (phase_q)
                    PH_FRAME: begin
                        // Bytes clocked in during the frame are ignored.
                        if (byte_cnt_q < LAST_FRAME) begin
                            byte_cnt_d = byte_cnt_q + 3'd1;
                        end else begin
                            phase_d = PH_POLL;
                        end
                    end
                    PH_POLL: begin
                        if (!rx_q[7]) begin
                            r1_d    = rx_q;
                            phase_d = PH_TRAILER;
                        end else if ((poll_cnt_q + 8'd1) == MAX_POLL_B) begin
                            timeout_d = 1'b1;
                            r1_d      = 8'hFF;
                            phase_d   = PH_TRAILER;
                        end else begin
                            poll_cnt_d = poll_cnt_q + 8'd1;
                        end
                    end
                    PH_TRAILER: begin
                        state_d = ST_FINISH;
                    end
                    default: begin
                        state_d = ST_FINISH;
                    end
                endcase
            end

            // Done, busy falling and CS rising all become visible together in
            // the following IDLE cycle, where a new start is already accepted.
            ST_FINISH: begin
                cs_n_d  = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign O_busy      = busy_q;
    assign O_done      = done_q;
    assign O_r1        = r1_q;
    assign O_timeout   = timeout_q;
    assign O_cs_n      = cs_n_q;
    assign O_spi_data  = spi_data_q;
    assign O_spi_read  = spi_read_q;
    assign O_spi_write = (state_q == ST_SEND) && !I_spi_busy;

endmodule
